// File: rtl/jpeg_idct_pkg.sv
// jpeg_idct_pkg: shared types and MCU slot table for the IDCT block scheduler
package jpeg_idct_pkg;
  typedef enum logic [1:0] {COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2} comp_t;
  typedef logic signed [11:0] coef_t;
  typedef logic signed [7:0] pix_t;
  typedef coef_t [7:0][7:0] coef_block_t;
  typedef pix_t [7:0][7:0] pix_block_t;
  localparam logic [5:0][1:0] MCU_SLOTS = {COMP_CR, COMP_CB, COMP_Y, COMP_Y, COMP_Y, COMP_Y};
  function automatic logic [1:0] comp_next(input logic [1:0] c);
    return c == 2'd2 ? 2'd0 : c + 2'd1;
  endfunction
endpackage

// File: rtl/idct_out_fifo.sv
// idct_out_fifo: synchronous FIFO holding finished pixel blocks with their component tag
module idct_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 514
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (push) mem[wr_q[AW-1:0]] <= din;
  end
  assign valid = wr_q != rd_q;
  assign dout = valid ? mem[rd_q[AW-1:0]] : '0;
endmodule

// File: rtl/idct_scheduler.sv
// idct_scheduler: credit-gated round-robin / 4:2:0 MCU block scheduler around a 2D IDCT
module idct_scheduler
  import jpeg_idct_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  coef_block_t [2:0] req_block,
  output logic              idct_valid_in,
  output coef_block_t       idct_in,
  input  logic              idct_valid_out,
  input  pix_block_t        idct_out,
  output logic              out_valid,
  input  logic              out_ready,
  output pix_block_t        out_block,
  output logic [1:0]        out_comp,
  output logic              err_unexpected
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int FW = $bits(pix_block_t) + 2;
  logic mode_q, mode_d, vin_q, vin_d, err_q, err_d;
  logic [1:0] rr_q, rr_d, gcomp_q, gcomp_d;
  logic [2:0] slot_q, slot_d;
  logic [CW-1:0] cred_q, cred_d;
  coef_block_t din_q, din_d;
  logic [PW-1:0] twr_q, twr_d, trd_q, trd_d;
  comp_t tag_mem [OUT_DEPTH];
  logic [1:0] p1, p2, mcu_c, gnt;
  logic [2:0] rr_pick, mcu_pick;
  logic xfer, tag_empty, res_ok, out_pop;
  logic [FW-1:0] fifo_dout;
  always_comb begin
    p1 = comp_next(rr_q);
    p2 = comp_next(p1);
    rr_pick = req_valid[rr_q] ? 3'b1 << rr_q : req_valid[p1] ? 3'b1 << p1 : req_valid[p2] ? 3'b1 << p2 : 3'b0;
    mcu_c = MCU_SLOTS[slot_q];
    mcu_pick = req_valid[mcu_c] ? 3'b1 << mcu_c : 3'b0;
    req_ready = (rst || cred_q == '0) ? 3'b0 : mode_q ? mcu_pick : rr_pick;
    xfer = |req_ready;
    gnt = req_ready[2] ? 2'd2 : req_ready[1] ? 2'd1 : 2'd0;
    tag_empty = twr_q == trd_q;
    res_ok = idct_valid_out & !tag_empty;
    out_pop = out_valid & out_ready;
    mode_d = slot_q == 3'd0 ? mode : mode_q;
    rr_d = (xfer && !mode_q) ? comp_next(gnt) : rr_q;
    slot_d = !mode_q ? 3'd0 : !xfer ? slot_q : slot_q == 3'd5 ? 3'd0 : slot_q + 3'd1;
    cred_d = cred_q - CW'(xfer) + CW'(out_pop);
    vin_d = xfer;
    din_d = xfer ? req_block[gnt] : din_q;
    gcomp_d = gnt;
    twr_d = twr_q + PW'(vin_q);
    trd_d = trd_q + PW'(res_ok);
    err_d = err_q | (idct_valid_out & tag_empty);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= mode;
      rr_q <= 2'd0;
      slot_q <= 3'd0;
      cred_q <= CW'(OUT_DEPTH);
      vin_q <= 1'b0;
      din_q <= '0;
      gcomp_q <= 2'd0;
      twr_q <= '0;
      trd_q <= '0;
      err_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      rr_q <= rr_d;
      slot_q <= slot_d;
      cred_q <= cred_d;
      vin_q <= vin_d;
      din_q <= din_d;
      gcomp_q <= gcomp_d;
      twr_q <= twr_d;
      trd_q <= trd_d;
      err_q <= err_d;
    end
    if (vin_q) tag_mem[twr_q[AW-1:0]] <= comp_t'(gcomp_q);
  end
  idct_out_fifo #(.DEPTH(OUT_DEPTH), .W(FW)) u_out_fifo (
    .clk(clk),
    .rst(rst),
    .push(res_ok),
    .pop(out_pop),
    .din({idct_out, tag_mem[trd_q[AW-1:0]]}),
    .dout(fifo_dout),
    .valid(out_valid)
  );
  assign {out_block, out_comp} = fifo_dout;
  assign idct_valid_in = vin_q;
  assign idct_in = din_q;
  assign err_unexpected = err_q;
endmodule

// File: doc/idct_scheduler.md
IDCT_SCHEDULER -- requirements
Module: idct_scheduler

Interface
REQ-001 Parameter OUT_DEPTH, default 4, output buffer depth in blocks and maximum in-flight blocks; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mode  input  1  0 = round-robin among components, 1 = 4:2:0 MCU order (Y,Y,Y,Y,Cb,Cr).
REQ-005 req_valid  input  3  per-component block request; bit 0 = Y, bit 1 = Cb, bit 2 = Cr.
REQ-006 req_ready  output  3  per-component accept; a block transfers when req_valid[i] & req_ready[i].
REQ-007 req_block  input  3 x 8x8 x 12 signed  coefficient block per component.
REQ-008 idct_valid_in  output  1  one-cycle strobe to the 2D IDCT.
REQ-009 idct_in  output  8x8 x 12 signed  block presented to the 2D IDCT.
REQ-010 idct_valid_out  input  1  2D IDCT result strobe.
REQ-011 idct_out  input  8x8 x 8 signed  2D IDCT result block.
REQ-012 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-013 out_block  output  8x8 x 8 signed  pixel block at FIFO head.
REQ-014 out_comp  output  2  component id of out_block (0 Y, 1 Cb, 2 Cr).
REQ-015 err_unexpected  output  1  sticky; IDCT result arrived with no outstanding tag.

Function
REQ-016 Credits = OUT_DEPTH - (in-flight blocks + FIFO occupancy); a grant is issued only when credits >= 1.
REQ-017 At most one grant per cycle; req_ready is one-hot or zero, combinational from req_valid, arbitration state and credits.
REQ-018 Round-robin mode: priority rotates from the component after the last granted; after reset Y is highest.
REQ-019 MCU mode: 3-bit slot counter 0..5 selects the only grantable component (slots 0-3 Y, 4 Cb, 5 Cr); counter advances only on a transfer and wraps 5 -> 0; no skipping of a stalled slot.
REQ-020 mode is sampled into an internal register only while slot = 0; in round-robin mode slot is held at 0.
REQ-021 Transfer at cycle N: idct_in registered from the granted req_block, idct_valid_in = 1 in cycle N+1 only; component id pushed to the in-order tag FIFO in cycle N+1.
REQ-022 idct_valid_out pops one tag and writes {idct_out, tag} into the output FIFO in the same cycle; in-flight count decrements.
REQ-023 idct_valid_out with empty tag FIFO: result dropped, err_unexpected set until reset.
REQ-024 out_valid = FIFO non-empty; pop on out_valid & out_ready; out_block/out_comp stable while out_valid & !out_ready.
REQ-025 Simultaneous grant and FIFO pop: credits unchanged; credits never negative, never above OUT_DEPTH.
REQ-026 Output order equals grant order; IDCT latency is not assumed by this block.

Reset
REQ-027 rst clears: req_ready=0, idct_valid_in=0, idct_in=0, out_valid=0, out_block=0, out_comp=0, err_unexpected=0, slot=0, round-robin pointer=Y, credits=OUT_DEPTH, both FIFOs empty, mode register=mode input.
REQ-028 rst mid-operation discards all in-flight tags and buffered blocks; the 2D IDCT shares rst, so no stale results are expected.

Structure
REQ-029 Package jpeg_idct_pkg holds comp_t (COMP_Y=0, COMP_CB=1, COMP_CR=2), coef_block_t (8x8 x 12 signed), pix_block_t (8x8 x 8 signed), MCU slot table constant.
REQ-030 One sub-module idct_out_fifo (synchronous FIFO, depth OUT_DEPTH, width pix_block_t + comp_t), instantiated for the output buffer; tag FIFO is a small in-module ring of comp_t.

Verification
REQ-031 mode=0, all three req_valid held high, out_ready=1, IDCT model latency 5 -> grants Y,Cb,Cr,Y,Cb,Cr...; out_comp in the same sequence.
REQ-032 mode=1, all valid, out_ready=1 -> out_comp repeats 0,0,0,0,1,2; with Cb withheld at slot 4, zero grants until Cb valid.
REQ-033 OUT_DEPTH=4, out_ready=0 -> exactly 4 transfers then req_ready=0; one out_ready pulse -> exactly one further grant.
REQ-034 idct_valid_out pulsed after reset with no grants -> err_unexpected=1 and stays 1; out_valid stays 0.
REQ-035 rst asserted with 3 blocks in flight and 1 buffered -> next cycle out_valid=0, credits=4, slot=0; subsequent stream correct.
REQ-036 Coefficient block DC=64, rest 0 -> out_block all 8-bit values equal the IDCT model output, tagged with the granted component.
